// File: rtl/bamf_io_pkg.sv
// Shared definitions for the BAMF I/O port unit.
//   DefaultDataW : default width of inport/outport data
//   CNT_*        : encoding of the cycle-counter state as seen on cnt_state_o
//   cnt_state_e  : typed state for the counter FSM, built on the CNT_* codes
package bamf_io_pkg;

  localparam int unsigned DefaultDataW = 16;

  localparam logic [1:0] CNT_IDLE = 2'b00;
  localparam logic [1:0] CNT_RUN  = 2'b01;
  localparam logic [1:0] CNT_DONE = 2'b10;

  typedef enum logic [1:0] {
    CntIdle = CNT_IDLE,
    CntRun  = CNT_RUN,
    CntDone = CNT_DONE
  } cnt_state_e;

endpackage

// File: rtl/bamf_io_fifo.sv
// Synchronous FIFO used as the outport result queue.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i, data_i : write request and data (ignored when full)
//   pop_i          : read request (ignored when empty)
//   data_o         : head entry, combinational, 0 when empty
//   full_o, empty_o: occupancy flags
module bamf_io_fifo
  import bamf_io_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = DefaultDataW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

  // Full is judged before any same-cycle pop, so a write into a full queue drops.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Stale storage is never exposed once the queue drains.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointers wrap by natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bamf_io_port.sv
// Processor-side I/O port for the BAMF datapath.
// Ports:
//   clk_i, reset_i              : clock, synchronous active-high reset
//   in_data_i/in_valid_i/in_ready_o    : host operand handshake into a 1-entry hold register
//   cpu_rd_i/cpu_rd_data_o/cpu_in_avail_o : CPU inport read of the held operand
//   cpu_wr_i/cpu_wr_data_i/cpu_out_full_o : CPU outport writes into the result FIFO
//   out_data_o/out_valid_o/out_ready_i : host drains the result FIFO
//   overflow_o                  : sticky, a CPU write was dropped on a full FIFO
//   cnt_clear_i/cycle_count_o/cnt_state_o : first-operand to first-result cycle counter
module bamf_io_port
  import bamf_io_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  input  logic              cpu_rd_i,
  output logic [DATA_W-1:0] cpu_rd_data_o,
  output logic              cpu_in_avail_o,
  input  logic              cpu_wr_i,
  input  logic [DATA_W-1:0] cpu_wr_data_i,
  output logic              cpu_out_full_o,
  output logic              overflow_o,
  input  logic              cnt_clear_i,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic [1:0]        cnt_state_o
);

  // ---------------------------------------------------------------------------
  // Input holding register
  // ---------------------------------------------------------------------------
  logic              in_full_q, in_full_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              host_accept;

  // A CPU read frees the slot in the same cycle, so back-to-back operands need no bubble.
  assign in_ready_o  = !in_full_q || cpu_rd_i;
  assign host_accept = in_valid_i && in_ready_o;

  always_comb begin
    in_full_d = in_full_q;
    in_data_d = in_data_q;
    if (host_accept) begin
      in_full_d = 1'b1;
      in_data_d = in_data_i;
    end else if (cpu_rd_i) begin
      in_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_full_q <= 1'b0;
      in_data_q <= '0;
    end else begin
      in_full_q <= in_full_d;
      in_data_q <= in_data_d;
    end
  end

  assign cpu_in_avail_o = in_full_q;
  assign cpu_rd_data_o  = in_full_q ? in_data_q : '0;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_push, fifo_pop;
  logic overflow_q, overflow_d;

  assign fifo_push = cpu_wr_i && !cpu_out_full_o;
  assign fifo_pop  = out_valid_o && out_ready_i;

  bamf_io_fifo #(
    .Depth (OUT_DEPTH),
    .Width (DATA_W)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  (cpu_wr_data_i),
    .pop_i   (fifo_pop),
    .data_o  (out_data_o),
    .full_o  (cpu_out_full_o),
    .empty_o (fifo_empty)
  );

  assign out_valid_o = !fifo_empty;

  assign overflow_d = overflow_q || (cpu_wr_i && cpu_out_full_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;

  // ---------------------------------------------------------------------------
  // Cycle counter FSM: first accepted operand to first accepted result write
  // ---------------------------------------------------------------------------
  cnt_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;

  // Saturating increment so a long run never wraps back to a small value.
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (cnt_clear_i) begin
      state_d = CntIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        CntIdle: begin
          if (host_accept) begin
            state_d = CntRun;
            count_d = CNT_W'(1);
          end
        end
        CntRun: begin
          // The cycle of the first result push is still counted.
          count_d = count_inc;
          if (fifo_push) state_d = CntDone;
        end
        CntDone: begin
          state_d = CntDone;
        end
        default: begin
          state_d = CntIdle;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CntIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign cycle_count_o = count_q;
  assign cnt_state_o   = state_q;

endmodule

// File: tb/tb_bamf_io_port.sv
// Self-checking bench for bamf_io_port: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_bamf_io_port;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cpu_rd;
  logic [15:0] cpu_rd_data;
  logic        cpu_in_avail;
  logic        cpu_wr;
  logic [15:0] cpu_wr_data;
  logic        cpu_out_full;
  logic        overflow;
  logic        cnt_clear;
  logic [31:0] cycle_count;
  logic [1:0]  cnt_state;

  bamf_io_port #(
    .DATA_W    (16),
    .OUT_DEPTH (4),
    .CNT_W     (32)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .cpu_rd_i       (cpu_rd),
    .cpu_rd_data_o  (cpu_rd_data),
    .cpu_in_avail_o (cpu_in_avail),
    .cpu_wr_i       (cpu_wr),
    .cpu_wr_data_i  (cpu_wr_data),
    .cpu_out_full_o (cpu_out_full),
    .overflow_o     (overflow),
    .cnt_clear_i    (cnt_clear),
    .cycle_count_o  (cycle_count),
    .cnt_state_o    (cnt_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: a held operand, a result queue and a stopwatch.
  bit          m_in_full;
  logic [15:0] m_in_data;
  logic [15:0] m_q[$];
  bit          m_ovf;
  int          m_state;  // 0 idle, 1 running, 2 done
  logic [31:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_full = 0;
    m_in_data = '0;
    m_q.delete();
    m_ovf   = 0;
    m_state = 0;
    m_cnt   = '0;
  endtask

  // Called just after a rising edge: compare outputs, advance the model, step one clock.
  task automatic tick();
    bit          e_rdy, e_full, e_vld, acc, push, pop;
    logic [15:0] e_head;
    #2;
    e_rdy  = !m_in_full || cpu_rd;
    e_full = (m_q.size() == 4);
    e_vld  = (m_q.size() != 0);
    e_head = e_vld ? m_q[0] : 16'h0;
    check_eq("in_ready", in_ready, e_rdy);
    check_eq("cpu_in_avail", cpu_in_avail, m_in_full);
    check_eq("cpu_rd_data", cpu_rd_data, m_in_full ? m_in_data : 16'h0);
    check_eq("out_valid", out_valid, e_vld);
    check_eq("out_data", out_data, e_head);
    check_eq("cpu_out_full", cpu_out_full, e_full);
    check_eq("overflow", overflow, m_ovf);
    check_eq("cnt_state", cnt_state, m_state);
    check_eq("cycle_count", cycle_count, m_cnt);

    acc  = in_valid && e_rdy;
    push = cpu_wr && !e_full;
    pop  = e_vld && out_ready;
    if (reset) begin
      model_reset();
    end else begin
      if (acc) begin
        m_in_full = 1;
        m_in_data = in_data;
      end else if (cpu_rd) begin
        m_in_full = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(cpu_wr_data);
      if (cpu_wr && e_full) m_ovf = 1;
      if (cnt_clear) begin
        m_state = 0;
        m_cnt   = 0;
      end else if (m_state == 0 && acc) begin
        m_state = 1;
        m_cnt   = 1;
      end else if (m_state == 1) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (push) m_state = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 0;
    cpu_rd    = 0;
    cpu_wr    = 0;
    out_ready = 0;
    cnt_clear = 0;
  endtask

  initial begin
    int popped;
    reset       = 1;
    in_data     = '0;
    cpu_wr_data = '0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    tick();
    reset = 0;

    // Reset state
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_cycle_count", cycle_count, 0);
    check_eq("rst_cnt_state", cnt_state, 0);
    check_eq("rst_overflow", overflow, 0);

    // 1: first operand starts the counter
    in_data = 16'h13B0;
    in_valid = 1;
    tick();
    in_valid = 0;
    check_eq("s1_avail", cpu_in_avail, 1);
    check_eq("s1_rd_data", cpu_rd_data, 16'h13B0);
    check_eq("s1_state", cnt_state, 1);
    check_eq("s1_count", cycle_count, 1);

    // 2: first result write stops it at 12
    repeat (10) tick();
    cpu_wr = 1;
    cpu_wr_data = 16'h0007;
    tick();
    cpu_wr = 0;
    check_eq("s2_out_valid", out_valid, 1);
    check_eq("s2_out_data", out_data, 16'h0007);
    check_eq("s2_state", cnt_state, 2);
    check_eq("s2_count", cycle_count, 12);
    repeat (20) tick();
    check_eq("s2_count_hold", cycle_count, 12);

    // 3: read and refill in the same cycle
    cpu_rd = 1;
    in_valid = 1;
    in_data = 16'h0005;
    #1;
    check_eq("s3_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    cpu_rd = 0;
    check_eq("s3_rd_data", cpu_rd_data, 16'h0005);
    check_eq("s3_avail", cpu_in_avail, 1);
    cpu_rd = 1;
    tick();
    cpu_rd = 0;

    // 4: fill, overflow, drain in order
    out_ready = 1;
    tick();
    out_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      cpu_wr = 1;
      cpu_wr_data = 16'(i);
      tick();
      if (i == 4) begin
        check_eq("s4_full", cpu_out_full, 1);
        check_eq("s4_no_ovf_yet", overflow, 0);
      end
    end
    cpu_wr = 0;
    check_eq("s4_overflow", overflow, 1);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check_eq("s4_drain", out_data, 16'(i));
      tick();
    end
    out_ready = 0;
    check_eq("s4_empty", out_valid, 0);

    // 5: write plus pop while full drops the write, leaving three entries
    for (int i = 0; i < 4; i++) begin
      cpu_wr = 1;
      cpu_wr_data = 16'hB000 + 16'(i);
      tick();
    end
    cpu_wr = 1;
    cpu_wr_data = 16'hAAAA;
    out_ready = 1;
    tick();
    cpu_wr = 0;
    check_eq("s5_overflow", overflow, 1);
    popped = 0;
    for (int k = 0; k < 8 && out_valid; k++) begin
      #1;
      check_eq("s5_drain", out_data, 16'hB001 + 16'(popped));
      popped++;
      tick();
    end
    out_ready = 0;
    check_eq("s5_occupancy", popped, 3);

    // 6: clear beats a simultaneous accept; reset discards queued data
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    in_valid = 1;
    in_data = 16'h0101;
    tick();
    in_valid = 0;
    check_eq("s6_run", cnt_state, 1);
    cpu_rd = 1;
    cnt_clear = 1;
    in_valid = 1;
    in_data = 16'h0202;
    tick();
    idle_inputs();
    check_eq("s6_clr_state", cnt_state, 0);
    check_eq("s6_clr_count", cycle_count, 0);
    cpu_wr = 1;
    cpu_wr_data = 16'h3333;
    tick();
    cpu_wr = 0;
    reset = 1;
    tick();
    reset = 0;
    check_eq("s6_rst_out_valid", out_valid, 0);
    check_eq("s6_rst_avail", cpu_in_avail, 0);
    check_eq("s6_rst_in_ready", in_ready, 1);
    check_eq("s6_rst_overflow", overflow, 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 99) < 40);
      in_data     = 16'($urandom);
      cpu_rd      = ($urandom_range(0, 99) < 35);
      cpu_wr      = ($urandom_range(0, 99) < 35);
      cpu_wr_data = 16'($urandom);
      out_ready   = ($urandom_range(0, 99) < 30);
      cnt_clear   = ($urandom_range(0, 99) < 2);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle_inputs();
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
